// File: rtl/mem_arb_pkg.sv
// Shared definitions for the main-memory access arbiter: FSM encoding,
// owner codes and default widths.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic OWNER_FETCH = 1'b0;
   localparam logic OWNER_DATA  = 1'b1;

   localparam int DEF_DATA_W     = 64;
   localparam int DEF_ADDR_W     = 5;
   localparam int DEF_MAX_STREAK = 4;

endpackage

// File: rtl/mem_arb_priority.sv
// Winner select between fetch and data requesters, plus the data-grant
// streak counter that bounds how long fetch can be starved.
module mem_arb_priority
   import mem_arb_pkg::*;
#(
   parameter int MAX_STREAK = DEF_MAX_STREAK
) (
   input  logic clk,
   input  logic rst_n,
   input  logic f_req,
   input  logic d_req,
   input  logic grant,
   output logic win
);

   localparam int STREAK_W = $clog2(MAX_STREAK + 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

   logic [STREAK_W-1:0] streak;

   // Data is preferred unless fetch is waiting and the streak has run out.
   always_comb begin
      win = OWNER_FETCH;
      if (d_req && !(f_req && (streak == STREAK_MAX))) begin
         win = OWNER_DATA;
      end
   end

   // Count consecutive data grants that left fetch waiting; any other grant clears.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         streak <= '0;
      end else if (grant) begin
         if ((win == OWNER_DATA) && f_req) begin
            if (streak != STREAK_MAX) begin
               streak <= streak + 1'b1;
            end
         end else begin
            streak <= '0;
         end
      end
   end

endmodule

// File: rtl/mem_access_arbiter.sv
// Sequences fetch and load/store traffic onto the single-port main memory:
// one command per transaction, fixed four-cycle turnaround, registered outputs.
module mem_access_arbiter
   import mem_arb_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int MAX_STREAK = DEF_MAX_STREAK
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              f_req,
   input  logic [ADDR_W-1:0] f_addr,
   output logic              f_ack,
   output logic [DATA_W-1:0] f_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              owner
);

   state_t state, state_n;

   logic              we_l, we_n;
   logic              grant, win;
   logic              mem_read_n, mem_write_n;
   logic [ADDR_W-1:0] mem_addr_n;
   logic [DATA_W-1:0] mem_wdata_n;
   logic              owner_n, busy_n;
   logic              f_ack_n, d_ack_n;
   logic [DATA_W-1:0] f_rdata_n, d_rdata_n;

   mem_arb_priority #(
      .MAX_STREAK (MAX_STREAK)
   ) u_prio (
      .clk   (clk),
      .rst_n (rst_n),
      .f_req (f_req),
      .d_req (d_req),
      .grant (grant),
      .win   (win)
   );

   // Next-state and next-output logic; every output is then registered.
   always_comb begin
      state_n     = state;
      we_n        = we_l;
      grant       = 1'b0;
      mem_read_n  = 1'b0;
      mem_write_n = 1'b0;
      mem_addr_n  = mem_addr;
      mem_wdata_n = mem_wdata;
      owner_n     = owner;
      f_ack_n     = 1'b0;
      d_ack_n     = 1'b0;
      f_rdata_n   = f_rdata;
      d_rdata_n   = d_rdata;
      case (state)
         IDLE: begin
            if (f_req || d_req) begin
               grant   = 1'b1;
               owner_n = win;
               if (win == OWNER_DATA) begin
                  mem_addr_n  = d_addr;
                  mem_wdata_n = d_wdata;
                  we_n        = d_we;
               end else begin
                  mem_addr_n  = f_addr;
                  we_n        = 1'b0;
               end
               mem_read_n  = !we_n;
               mem_write_n = we_n;
               state_n     = ISSUE;
            end
         end
         ISSUE: begin
            state_n = WAIT;
         end
         WAIT: begin
            // Memory output is valid now, one cycle after the read was presented.
            if (owner == OWNER_DATA) begin
               d_rdata_n = mem_rdata;
               d_ack_n   = 1'b1;
            end else begin
               f_rdata_n = mem_rdata;
               f_ack_n   = 1'b1;
            end
            state_n = DONE;
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
      busy_n = (state_n != IDLE);
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Command latches, response registers and status outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         we_l      <= 1'b0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         owner     <= OWNER_FETCH;
         busy      <= 1'b0;
         f_ack     <= 1'b0;
         d_ack     <= 1'b0;
         f_rdata   <= '0;
         d_rdata   <= '0;
      end else begin
         we_l      <= we_n;
         mem_read  <= mem_read_n;
         mem_write <= mem_write_n;
         mem_addr  <= mem_addr_n;
         mem_wdata <= mem_wdata_n;
         owner     <= owner_n;
         busy      <= busy_n;
         f_ack     <= f_ack_n;
         d_ack     <= d_ack_n;
         f_rdata   <= f_rdata_n;
         d_rdata   <= d_rdata_n;
      end
   end

endmodule

// File: doc/mem_access_arbiter.md
Name: mem_access_arbiter

Overview:
- Sequences all traffic to the single-port 64-bit word main memory. Two requesters share it: the instruction-fetch port (read-only) and the load/store data port.
- Arbitrates between the two requesters, issues one memory command per transaction and returns an acknowledge with read data.
- Sits between the fetch/LSU control logic and main_memory. Drives main_memory's MemRead/MemWrite/address/store-data inputs and consumes its registered out_load.

Parameters:
DATA_W, 64, memory word width
ADDR_W, 5, word-index width (32 words)
MAX_STREAK, 4, consecutive data grants allowed while fetch waits before fetch is forced

Ports:
clk  in  1  clock; all state changes on posedge
rst_n  in  1  synchronous active-low reset
f_req  in  1  fetch request; held high until f_ack
f_addr  in  ADDR_W  fetch word index; stable while f_req high
f_ack  out  1  one-cycle pulse; fetch transaction complete
f_rdata  out  DATA_W  fetch read data; valid when f_ack=1
d_req  in  1  data request; held high until d_ack
d_we  in  1  1=store, 0=load; stable while d_req high
d_addr  in  ADDR_W  data word index
d_wdata  in  DATA_W  store data
d_ack  out  1  one-cycle pulse; data transaction complete
d_rdata  out  DATA_W  load data; valid when d_ack=1 and d_we=0
mem_read  out  1  to memory MemRead
mem_write  out  1  to memory MemWrite
mem_addr  out  ADDR_W  to memory address (load and store)
mem_wdata  out  DATA_W  to memory store data
mem_rdata  in  DATA_W  from memory; valid the cycle after a read is issued
busy  out  1  high in any state other than IDLE
owner  out  1  0=fetch, 1=data; the current or most recent grant

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, all outputs 0, streak=0, owner=0. Reset overrides every other event.
- Reset during ISSUE: the memory command already presented that cycle still takes effect in memory (memory has no reset). No ack is ever produced for it.
- Registered outputs: every output comes from a flop.
- FSM states and transitions:
  - IDLE: if any req is high, arbitrate, latch the winner's addr/we/wdata into mem_* and go to ISSUE.
  - ISSUE: mem_read = !we_latched; mem_write = we_latched (store only when owner=data). Exactly one cycle, then go to WAIT.
  - WAIT: mem_read/mem_write = 0. At the end of this cycle, capture mem_rdata into the owner's rdata register and set the owner's ack. Go to DONE.
  - DONE: ack high for exactly this cycle. Go to IDLE. Requests are not sampled in DONE.
- Latency: req rising at cycle 0 (IDLE) -> ISSUE in cycle 1 -> WAIT in cycle 2 -> ack in cycle 3. Loads and stores have identical latency.
- Requester handshake: the requester drops or changes req in the cycle after ack. The earliest next grant is from IDLE in cycle 4, so throughput is one transaction per 4 cycles.
- Arbitration at IDLE:
  - Only one requester high: it wins.
  - Both high: data wins unless streak==MAX_STREAK, in which case fetch wins.
- Streak counter (width = clog2(MAX_STREAK+1)):
  - Data grant with f_req high: increment, saturating at MAX_STREAK.
  - Data grant with f_req low: clear to 0.
  - Any fetch grant: clear to 0.
- Unused rdata on the other port holds its last value. d_rdata after a store: loaded with mem_rdata (don't-care for the requester).
- Requests dropped before ack are a protocol violation; the arbiter completes the transaction anyway.
- Addresses wrap naturally within ADDR_W. No range checking.

Decomposition:
- Shared package mem_arb_pkg:
  - state encoding: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, DONE=2'd3
  - OWNER_FETCH=1'b0, OWNER_DATA=1'b1
  - default DATA_W/ADDR_W constants
- One natural sub-module: mem_arb_priority. Combinational winner select plus the streak counter register; takes f_req, d_req, and a grant strobe.
- FSM, command latches and response registers stay in the top.

Test Plan:
- Reset: hold rst_n=0 3 cycles while both req high -> all outputs 0, busy=0, no ack. Release -> data granted in the first IDLE cycle.
- Single load: d_req=1, d_we=0, d_addr=5'd7, memory[7]=64'hDEAD_BEEF_0000_0007 -> mem_read=1 only in cycle 1 with mem_addr=7. d_ack=1 only in cycle 3 with d_rdata=64'hDEAD_BEEF_0000_0007.
- Store then load: store d_addr=3, d_wdata=64'h1234 -> mem_write=1 for one cycle, d_ack at cycle 3. Then load addr 3 -> d_rdata=64'h1234.
- Simultaneous requests, single data: f_req and d_req both high at cycle 0, streak=0 -> data granted first (owner=1), d_ack at cycle 3. Fetch granted from the next IDLE, f_ack 4 cycles later.
- Starvation bound with MAX_STREAK=4: d_req held continuously (new transaction each time) and f_req held high -> grant order D,D,D,D,F,D. Streak reads 0 after the fetch grant.
- Reset mid-operation: pulse rst_n=0 during WAIT of a load -> no d_ack ever, state IDLE next cycle. Reset during ISSUE of a store to addr 9 -> memory[9] updated, no d_ack.
